// File: rtl/integrate_sched_pkg.sv
// rtl/integrate_sched_pkg.sv - shared ceil-log2, ID width derivation and tag layout for integrate_sched
package integrate_sched_pkg;

  // Tag id field is sized for up to 256 requesters; users slice off the low id_width() bits.
  localparam int TAG_ID_MAX_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int id_width(input int req_num);
    return (clog2(req_num) < 1) ? 1 : clog2(req_num);
  endfunction

  typedef struct packed {
    logic                    valid;
    logic                    last;
    logic [TAG_ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/integrate_sched_if.sv
// rtl/integrate_sched_if.sv - requester-side and result-side bus of integrate_sched
interface integrate_sched_if #(
  parameter int IN_NUM    = 4,
  parameter int BIT_WIDTH = 8,
  parameter int REQ_NUM   = 3,
  parameter int ACC_WIDTH = 16
) ();
  localparam int ID_W = integrate_sched_pkg::id_width(REQ_NUM);

  logic [REQ_NUM-1:0]                    in_req;
  logic [REQ_NUM-1:0]                    in_last;
  logic [0:REQ_NUM*IN_NUM*BIT_WIDTH-1]   in_values;
  logic [REQ_NUM-1:0]                    in_ack;
  logic                                  out_valid;
  logic [ID_W-1:0]                       out_id;
  logic [ACC_WIDTH-1:0]                  out_value;

  modport master (
    output in_req, in_last, in_values,
    input  in_ack, out_valid, out_id, out_value
  );

  modport slave (
    input  in_req, in_last, in_values,
    output in_ack, out_valid, out_id, out_value
  );
endinterface

// File: rtl/integrate.sv
// rtl/integrate.sv - pipelined binary adder tree, one register per level, sum wraps at BIT_WIDTH
module integrate import integrate_sched_pkg::*; #(
  parameter int IN_NUM    = 4,
  parameter int BIT_WIDTH = 8
) (
  input  logic                            clock,
  input  logic [0:IN_NUM*BIT_WIDTH-1]     in_values,
  output logic [BIT_WIDTH-1:0]            out_value
);
  localparam int L = clog2(IN_NUM);
  localparam int P = 1 << L;

  logic [BIT_WIDTH-1:0] leaf [P];

  always_comb begin
    for (int i = 0; i < P; i++) leaf[i] = '0;
    for (int i = 0; i < IN_NUM; i++) leaf[i] = in_values[i*BIT_WIDTH +: BIT_WIDTH];
  end

  generate
    if (L == 0) begin : g_wire
      assign out_value = leaf[0];
    end else begin : g_tree
      // Heap layout: node n sums nodes 2n and 2n+1; indices P..2P-1 are the leaves.
      logic [BIT_WIDTH-1:0] node_q [1:P-1];
      logic [BIT_WIDTH-1:0] heap   [1:2*P-1];

      always_comb begin
        for (int n = 1; n < P; n++) heap[n] = node_q[n];
        for (int i = 0; i < P; i++) heap[P+i] = leaf[i];
      end

      always_ff @(posedge clock) begin
        for (int n = 1; n < P; n++) node_q[n] <= heap[2*n] + heap[2*n+1];
      end

      assign out_value = node_q[1];
    end
  endgenerate
endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer moves past each winner
module rr_arbiter import integrate_sched_pkg::*; #(
  parameter int REQ_NUM = 3,
  parameter int ID_W    = id_width(REQ_NUM)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [REQ_NUM-1:0] req_i,
  output logic [REQ_NUM-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               grant_valid_o
);
  logic [ID_W-1:0] ptr_q, ptr_d;

  function automatic int wrap_idx(input int base, input int k);
    return (base + k >= REQ_NUM) ? base + k - REQ_NUM : base + k;
  endfunction

  // Scan from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    grant_o       = '0;
    grant_id_o    = '0;
    grant_valid_o = 1'b0;
    ptr_d         = ptr_q;
    if (!reset) begin
      for (int k = REQ_NUM - 1; k >= 0; k--) begin
        if (req_i[wrap_idx(int'(ptr_q), k)]) begin
          grant_o                              = '0;
          grant_o[wrap_idx(int'(ptr_q), k)]    = 1'b1;
          grant_id_o                           = ID_W'(wrap_idx(int'(ptr_q), k));
          grant_valid_o                        = 1'b1;
        end
      end
      if (grant_valid_o) ptr_d = ID_W'(wrap_idx(int'(grant_id_o), 1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/integrate_sched.sv
// rtl/integrate_sched.sv - round-robin sharing of one integrate tree with per-requester packet sums
// Optional INTEG_SCHED_OUTREG_EN adds one output register stage (latency L+2).
module integrate_sched import integrate_sched_pkg::*; #(
  parameter int IN_NUM    = 4,
  parameter int BIT_WIDTH = 8,
  parameter int REQ_NUM   = 3,
  parameter int ACC_WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  integrate_sched_if.slave   bus
);
  localparam int L       = clog2(IN_NUM);
  localparam int ID_W    = id_width(REQ_NUM);
  localparam int SLICE_W = IN_NUM * BIT_WIDTH;

  logic [REQ_NUM-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_valid;
  logic [0:SLICE_W-1]   tree_in;
  logic [BIT_WIDTH-1:0] tree_sum;
  tag_t                 tag_in, tag_out;

  rr_arbiter #(.REQ_NUM(REQ_NUM), .ID_W(ID_W)) u_arb (
    .clock         (clock),
    .reset         (reset),
    .req_i         (bus.in_req),
    .grant_o       (grant),
    .grant_id_o    (grant_id),
    .grant_valid_o (grant_valid)
  );

  assign bus.in_ack = grant;

  always_comb begin
    tree_in      = '0;
    tag_in       = '0;
    tag_in.valid = grant_valid;
    tag_in.last  = |(grant & bus.in_last);
    tag_in.id    = TAG_ID_MAX_W'(grant_id);
    if (grant_valid) tree_in = bus.in_values[int'(grant_id)*SLICE_W +: SLICE_W];
  end

  integrate #(.IN_NUM(IN_NUM), .BIT_WIDTH(BIT_WIDTH)) u_tree (
    .clock     (clock),
    .in_values (tree_in),
    .out_value (tree_sum)
  );

  generate
    if (L == 0) begin : g_tag_wire
      assign tag_out = tag_in;
    end else begin : g_tag_pipe
      tag_t tag_q [L];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < L; i++) tag_q[i] <= '0;
        end else begin
          tag_q[0] <= tag_in;
          for (int i = 1; i < L; i++) tag_q[i] <= tag_q[i-1];
        end
      end
      assign tag_out = tag_q[L-1];
    end
  endgenerate

  logic [ID_W-1:0]      tag_id;
  logic                 tag_id_unused;
  logic [ACC_WIDTH-1:0] acc_q [REQ_NUM];
  logic [ACC_WIDTH-1:0] sum_d;
  logic                 out_valid_q;
  logic [ID_W-1:0]      out_id_q;
  logic [ACC_WIDTH-1:0] out_value_q;

  assign tag_id        = tag_out.id[ID_W-1:0];
  assign tag_id_unused = ^tag_out.id;
  assign sum_d         = acc_q[tag_id] + ACC_WIDTH'(tree_sum);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < REQ_NUM; r++) acc_q[r] <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_value_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (tag_out.valid) begin
        if (tag_out.last) begin
          out_valid_q   <= 1'b1;
          out_id_q      <= tag_id;
          out_value_q   <= sum_d;
          acc_q[tag_id] <= '0;
        end else begin
          acc_q[tag_id] <= sum_d;
        end
      end
    end
  end

`ifdef INTEG_SCHED_OUTREG_EN
  logic                 outreg_valid_q;
  logic [ID_W-1:0]      outreg_id_q;
  logic [ACC_WIDTH-1:0] outreg_value_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      outreg_valid_q <= 1'b0;
      outreg_id_q    <= '0;
      outreg_value_q <= '0;
    end else begin
      outreg_valid_q <= out_valid_q;
      outreg_id_q    <= out_id_q;
      outreg_value_q <= out_value_q;
    end
  end

  assign bus.out_valid = outreg_valid_q;
  assign bus.out_id    = outreg_id_q;
  assign bus.out_value = outreg_value_q;
`else
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_value = out_value_q;
`endif
endmodule

// File: tb/tb_integrate_sched.sv
// tb/tb_integrate_sched.sv - self-checking bench for integrate_sched with a packet-level reference model
module tb_integrate_sched;
  localparam int IN_NUM    = 4;
  localparam int BIT_WIDTH = 8;
  localparam int REQ_NUM   = 3;
  localparam int ACC_WIDTH = 16;
`ifdef INTEG_SCHED_OUTREG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  integrate_sched_if #(.IN_NUM(IN_NUM), .BIT_WIDTH(BIT_WIDTH), .REQ_NUM(REQ_NUM), .ACC_WIDTH(ACC_WIDTH)) bus ();

  integrate_sched #(.IN_NUM(IN_NUM), .BIT_WIDTH(BIT_WIDTH), .REQ_NUM(REQ_NUM), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed { logic last; logic [31:0] vals; } beat_t;
  typedef struct { int cyc; int id; int val; } exp_t;

  beat_t rq [REQ_NUM][$];
  exp_t  exp_q [$];
  int    model_acc [REQ_NUM];
  int    mptr = 0;
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  bit    chk_en = 0;
  int    ack_id_log[$], ack_cyc_log[$], ev_id_log[$], ev_val_log[$], ev_cyc_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc++;

  // Requester model: present the head beat of each queue, advance on ack.
  always @(posedge clock) begin
    #1;
    for (int r = 0; r < REQ_NUM; r++) begin
      if (rq[r].size() > 0) begin
        bus.in_req[r]  = 1'b1;
        bus.in_last[r] = rq[r][0].last;
        for (int e = 0; e < IN_NUM; e++)
          bus.in_values[(r*IN_NUM+e)*BIT_WIDTH +: BIT_WIDTH] = rq[r][0].vals[e*8 +: 8];
      end else begin
        bus.in_req[r]  = 1'b0;
        bus.in_last[r] = 1'b0;
      end
    end
  end

  always @(negedge clock) begin : mon
    int   g;
    int   s;
    exp_t ex;
    logic [REQ_NUM-1:0] exp_ack;
    if (chk_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        chk("out_valid", bus.out_valid, 1);
        chk("out_id", bus.out_id, exp_q[0].id);
        chk("out_value", bus.out_value, exp_q[0].val);
        void'(exp_q.pop_front());
      end else begin
        chk("out_valid_idle", bus.out_valid, 0);
      end
      if (bus.out_valid === 1'b1) begin
        ev_id_log.push_back(int'(bus.out_id));
        ev_val_log.push_back(int'(bus.out_value));
        ev_cyc_log.push_back(cyc);
      end
      g = -1;
      if (reset !== 1'b1)
        for (int k = 0; k < REQ_NUM; k++)
          if (g < 0 && bus.in_req[(mptr + k) % REQ_NUM]) g = (mptr + k) % REQ_NUM;
      exp_ack = '0;
      if (g >= 0) exp_ack[g] = 1'b1;
      chk("in_ack", bus.in_ack, exp_ack);
      if (reset === 1'b1) begin
        for (int r = 0; r < REQ_NUM; r++) model_acc[r] = 0;
        mptr = 0;
        exp_q.delete();
      end else if (g >= 0) begin
        s = 0;
        for (int e = 0; e < IN_NUM; e++)
          s += int'(bus.in_values[(g*IN_NUM+e)*BIT_WIDTH +: BIT_WIDTH]);
        model_acc[g] = (model_acc[g] + (s % 256)) % 65536;
        if (bus.in_last[g]) begin
          ex.cyc = cyc + LAT;
          ex.id  = g;
          ex.val = model_acc[g];
          exp_q.push_back(ex);
          model_acc[g] = 0;
        end
        mptr = (g + 1) % REQ_NUM;
        ack_id_log.push_back(g);
        ack_cyc_log.push_back(cyc);
      end
    end
    for (int r = 0; r < REQ_NUM; r++)
      if (bus.in_ack[r] === 1'b1 && rq[r].size() > 0) void'(rq[r].pop_front());
  end

  task automatic push(input int r, input logic last, input logic [31:0] vals);
    beat_t b;
    b.last = last;
    b.vals = vals;
    rq[r].push_back(b);
  endtask

  task automatic clear_logs();
    ack_id_log.delete(); ack_cyc_log.delete();
    ev_id_log.delete(); ev_val_log.delete(); ev_cyc_log.delete();
  endtask

  task automatic apply_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    int pend;
    n = 0;
    pend = 1;
    while (pend != 0 && n < 200) begin
      @(negedge clock);
      n++;
      pend = exp_q.size();
      for (int r = 0; r < REQ_NUM; r++) pend += rq[r].size();
    end
    chk("idle_within_budget", (n < 200), 1);
    repeat (4) @(negedge clock);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s2_ids [6];
    int s2_vals [6];
    int n;
    s2_ids  = '{0, 1, 2, 0, 1, 2};
    s2_vals = '{4, 12, 20, 8, 16, 24};
    bus.in_req    = '0;
    bus.in_last   = '0;
    bus.in_values = '0;
    repeat (2) @(posedge clock);
    #2 chk_en = 1;
    @(negedge clock); #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_id", bus.out_id, 0);
    chk("reset_out_value", bus.out_value, 0);
    chk("reset_in_ack", bus.in_ack, 0);
    @(posedge clock); #1 reset = 1'b0;

    // 1: single-beat packet from r0
    apply_reset(); clear_logs();
    push(0, 1'b1, 32'h04030201);
    wait_idle();
    chk("s1_count", ev_val_log.size(), 1);
    if (ev_val_log.size() == 1 && ack_cyc_log.size() == 1) begin
      chk("s1_id", ev_id_log[0], 0);
      chk("s1_value", ev_val_log[0], 10);
      chk("s1_latency", ev_cyc_log[0] - ack_cyc_log[0], LAT);
    end

    // 2: all three requesting, two single-beat packets each
    apply_reset(); clear_logs();
    push(0, 1'b1, 32'h01010101); push(1, 1'b1, 32'h03030303); push(2, 1'b1, 32'h05050505);
    push(0, 1'b1, 32'h02020202); push(1, 1'b1, 32'h04040404); push(2, 1'b1, 32'h06060606);
    wait_idle();
    chk("s2_acks", ack_id_log.size(), 6);
    chk("s2_count", ev_val_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < ack_id_log.size()) chk("s2_ack_order", ack_id_log[i], s2_ids[i]);
      if (i > 0 && i < ack_cyc_log.size()) chk("s2_ack_back_to_back", ack_cyc_log[i] - ack_cyc_log[i-1], 1);
      if (i < ev_val_log.size()) begin
        chk("s2_out_id", ev_id_log[i], s2_ids[i]);
        chk("s2_out_value", ev_val_log[i], s2_vals[i]);
        if (i < ack_cyc_log.size()) chk("s2_latency", ev_cyc_log[i] - ack_cyc_log[i], LAT);
      end
    end

    // 3: three-beat packet on r1 with wrapping tree sums
    apply_reset(); clear_logs();
    push(1, 1'b0, 32'hFFFFFFFF); push(1, 1'b0, 32'hFFFFFFFF); push(1, 1'b1, 32'h00000001);
    wait_idle();
    chk("s3_count", ev_val_log.size(), 1);
    if (ev_val_log.size() == 1) begin
      chk("s3_id", ev_id_log[0], 1);
      chk("s3_value", ev_val_log[0], 505);
    end

    // 5: reset right after a partial r1 beat discards it
    apply_reset(); clear_logs();
    push(1, 1'b0, 32'h09090909);
    n = 0;
    while (rq[1].size() != 0 && n < 50) begin @(negedge clock); n++; end
    chk("s5_partial_acked", (n < 50), 1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    push(1, 1'b1, 32'h01010101);
    wait_idle();
    chk("s5_count", ev_val_log.size(), 1);
    if (ev_val_log.size() == 1) begin
      chk("s5_id", ev_id_log[0], 1);
      chk("s5_value", ev_val_log[0], 4);
    end

    // 4: interleaved two-beat packets on r0 and r2
    apply_reset(); clear_logs();
    push(0, 1'b0, 32'h01010101); push(0, 1'b1, 32'h02020202);
    push(2, 1'b0, 32'h00000005); push(2, 1'b1, 32'h05000000);
    wait_idle();
    chk("s4_acks", ack_id_log.size(), 4);
    if (ack_id_log.size() == 4) begin
      chk("s4_ack0", ack_id_log[0], 0);
      chk("s4_ack1", ack_id_log[1], 2);
      chk("s4_ack2", ack_id_log[2], 0);
      chk("s4_ack3", ack_id_log[3], 2);
    end
    chk("s4_count", ev_val_log.size(), 2);
    if (ev_val_log.size() == 2) begin
      chk("s4_first_id", ev_id_log[0], 0);
      chk("s4_first_value", ev_val_log[0], 12);
      chk("s4_second_id", ev_id_log[1], 2);
      chk("s4_second_value", ev_val_log[1], 10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
